// File: rtl/adder_tree_pkg.sv
// Shared helpers for adder_tree_acc: tree geometry, widths and saturation bounds.
// Combinational constants only; no latency, no backpressure.
package adder_tree_pkg;

  localparam int DEF_NUM_IN = 9;
  localparam int DEF_DATA_W = 20;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_OUT_W  = 20;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Width of the results produced by tree level n (0-based).
  function automatic int lvl_w(input int data_w, input int n);
    return data_w + n + 1;
  endfunction

  // Number of entries entering tree level n.
  function automatic int lvl_cnt(input int num_in, input int n);
    return (num_in + (1 << n) - 1) >> n;
  endfunction

  function automatic logic signed [63:0] sat_max(input int out_w);
    return (64'sd1 <<< (out_w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int out_w);
    return -(64'sd1 <<< (out_w - 1));
  endfunction

  localparam logic signed [63:0] DEF_SAT_MAX = sat_max(DEF_OUT_W);
  localparam logic signed [63:0] DEF_SAT_MIN = sat_min(DEF_OUT_W);

endpackage

// File: rtl/adder_tree_level.sv
// One registered reduction level: pairs (2j, 2j+1) summed, odd leftover passed through.
// Latency 1 cycle; free-running, no backpressure.
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int N_IN = 9,
  parameter int IN_W = 20
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [N_IN*IN_W-1:0]               i_dat,
  output logic [((N_IN+1)/2)*(IN_W+1)-1:0]   o_dat
);

  localparam int N_OUT = (N_IN + 1) / 2;
  localparam int OUT_W = IN_W + 1;
  localparam int PAD_W = 2 * N_OUT * IN_W;

  logic [PAD_W-1:0]       din_pad;
  logic [N_OUT*OUT_W-1:0] sum_d;
  logic [N_OUT*OUT_W-1:0] sum_q;

  // Zero padding makes the odd leftover add to 0, i.e. pass through unchanged.
  assign din_pad = PAD_W'(i_dat);

  always_comb begin
    sum_d = '0;
    for (int j = 0; j < N_OUT; j++) begin
      sum_d[j*OUT_W +: OUT_W] = OUT_W'($signed(din_pad[(2*j)*IN_W +: IN_W]))
                              + OUT_W'($signed(din_pad[(2*j+1)*IN_W +: IN_W]));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign o_dat = sum_q;

endmodule

// File: rtl/adder_tree_acc.sv
// Pipelined signed adder tree with first/last framed accumulation; latency LEVELS+1, no backpressure.
// Define ADDER_TREE_SAT_EN to clamp the frame result to OUT_W and report o_ovf; otherwise results wrap.
module adder_tree_acc
  import adder_tree_pkg::*;
#(
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic                     i_first,
  input  logic                     i_last,
  input  logic [NUM_IN*DATA_W-1:0] i_data,
  output logic                     o_valid,
  output logic [OUT_W-1:0]         o_data,
  output logic                     o_ovf
);

  localparam int LEVELS = clog2(NUM_IN);
  localparam int TREE_W = DATA_W + LEVELS;

  // Reduction tree: level n consumes lvl_cnt(n) entries of DATA_W+n bits.
  for (genvar n = 0; n < LEVELS; n++) begin : g_lvl
    localparam int NI = lvl_cnt(NUM_IN, n);
    localparam int NO = lvl_cnt(NUM_IN, n + 1);
    localparam int IW = DATA_W + n;
    localparam int OW = lvl_w(DATA_W, n);

    logic [NI*IW-1:0] lvl_in;
    logic [NO*OW-1:0] lvl_dat;

    if (n == 0) begin : g_src
      assign lvl_in = i_data;
    end else begin : g_src
      assign lvl_in = g_lvl[n-1].lvl_dat;
    end

    adder_tree_level #(
      .N_IN (NI),
      .IN_W (IW)
    ) u_level (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_dat (lvl_in),
      .o_dat (lvl_dat)
    );
  end

  logic [TREE_W-1:0]       tree_dat;
  logic signed [ACC_W-1:0] tree_sum;

  assign tree_dat = g_lvl[LEVELS-1].lvl_dat;
  assign tree_sum = ACC_W'($signed(tree_dat));

  // Flags are qualified by i_valid on entry so idle cycles carry no stale first/last.
  logic [LEVELS-1:0] vld_d,   vld_q;
  logic [LEVELS-1:0] first_d, first_q;
  logic [LEVELS-1:0] last_d,  last_q;

  always_comb begin
    vld_d      = '0;
    first_d    = '0;
    last_d     = '0;
    vld_d[0]   = i_valid;
    first_d[0] = i_valid & i_first;
    last_d[0]  = i_valid & i_last;
    for (int k = 1; k < LEVELS; k++) begin
      vld_d[k]   = vld_q[k-1];
      first_d[k] = first_q[k-1];
      last_d[k]  = last_q[k-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else begin
      vld_q   <= vld_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  logic                    beat_vld;
  logic                    beat_first;
  logic                    beat_last;
  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic signed [ACC_W-1:0] sum_res;
  logic [OUT_W-1:0]        res_dat;
  logic                    res_ovf;

  assign beat_vld   = vld_q[LEVELS-1];
  assign beat_first = first_q[LEVELS-1];
  assign beat_last  = last_q[LEVELS-1];

  assign sum_res = beat_first ? tree_sum : acc_q + tree_sum;

`ifdef ADDER_TREE_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(OUT_W));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(OUT_W));

  always_comb begin
    res_dat = sum_res[OUT_W-1:0];
    res_ovf = 1'b0;
    if (sum_res > SAT_HI) begin
      res_dat = SAT_HI[OUT_W-1:0];
      res_ovf = 1'b1;
    end else if (sum_res < SAT_LO) begin
      res_dat = SAT_LO[OUT_W-1:0];
      res_ovf = 1'b1;
    end
  end
`else
  always_comb begin
    res_dat = sum_res[OUT_W-1:0];
    res_ovf = 1'b0;
  end
`endif

  logic             ovld_d, ovld_q;
  logic [OUT_W-1:0] odat_d, odat_q;
  logic             ovf_d,  ovf_q;

  // The accumulator empties on last so a following orphan beat starts from 0.
  always_comb begin
    acc_d  = acc_q;
    ovld_d = 1'b0;
    odat_d = odat_q;
    ovf_d  = ovf_q;
    if (beat_vld) begin
      if (beat_last) begin
        acc_d  = '0;
        ovld_d = 1'b1;
        odat_d = res_dat;
        ovf_d  = res_ovf;
      end else begin
        acc_d  = sum_res;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q  <= '0;
      ovld_q <= 1'b0;
      odat_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      ovld_q <= ovld_d;
      odat_q <= odat_d;
      ovf_q  <= ovf_d;
    end
  end

  assign o_valid = ovld_q;
  assign o_data  = odat_q;
  assign o_ovf   = ovf_q;

endmodule
